// File: rtl/bullet_pkg.sv
// Shared types and default constants for the bullet engine: facing directions,
// engine phases, playfield defaults and the saturating damage adder.
package bullet_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_CHECK, ST_REPORT} state_t;

  localparam int DEF_SPEED    = 8;
  localparam int DEF_RADIUS   = 8;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DMG_W        = 7;
  localparam logic [DMG_W-1:0] DMG_MAX = 7'd127;

  function automatic logic [DMG_W-1:0] sat_add(input logic [DMG_W-1:0] a,
                                               input logic [DMG_W-1:0] b);
    logic [DMG_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, DMG_MAX}) ? DMG_MAX : s[DMG_W-1:0];
  endfunction

endpackage

// File: rtl/bullet_hit_check.sv
// Combinational test of one bullet against every zombie box: returns the full
// match mask and the index of the lowest matching zombie.
module bullet_hit_check
  import bullet_pkg::*;
#(
  parameter int NUM_ZOMBIE = 10,
  parameter int HIT_RADIUS = DEF_RADIUS,
  localparam int ZW = (NUM_ZOMBIE > 1) ? $clog2(NUM_ZOMBIE) : 1
) (
  input  logic [9:0]            bx,
  input  logic [9:0]            by,
  input  logic [9:0]            zx [NUM_ZOMBIE],
  input  logic [9:0]            zy [NUM_ZOMBIE],
  input  logic [NUM_ZOMBIE-1:0] exist,
  output logic [NUM_ZOMBIE-1:0] match,
  output logic [ZW-1:0]         first
);

  localparam logic [9:0] RAD = 10'(HIT_RADIUS);

  logic [9:0] dx [NUM_ZOMBIE];
  logic [9:0] dy [NUM_ZOMBIE];

  for (genvar z = 0; z < NUM_ZOMBIE; z++) begin : g_cmp
    assign dx[z]    = (bx >= zx[z]) ? (bx - zx[z]) : (zx[z] - bx);
    assign dy[z]    = (by >= zy[z]) ? (by - zy[z]) : (zy[z] - by);
    assign match[z] = exist[z] && (dx[z] < RAD) && (dy[z] < RAD);
  end

  // Downward scan so the final assignment is the lowest matching index.
  always_comb begin
    first = '0;
    for (int z = NUM_ZOMBIE - 1; z >= 0; z--) begin
      if (match[z]) first = ZW'(z);
    end
  end

endmodule

// File: rtl/bullet_tracker.sv
// Bullet pool: spawns shots in IDLE, then per frame runs MOVE, CHECK (one slot
// per cycle) and REPORT. Define BULLET_PIERCE_EN for bullets that survive hits.
module bullet_tracker
  import bullet_pkg::*;
#(
  parameter int NUM_SLOTS    = 8,
  parameter int NUM_ZOMBIE   = 10,
  parameter int BULLET_SPEED = DEF_SPEED,
  parameter int HIT_RADIUS   = DEF_RADIUS,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic                  Start,
  input  logic [1:0]            If_Shot,
  input  logic [6:0]            Bullet_Damage [2],
  input  logic [9:0]            Player_X [2],
  input  logic [9:0]            Player_Y [2],
  input  logic [1:0]            Player_Dir [2],
  input  logic [9:0]            RedBox_X [NUM_ZOMBIE],
  input  logic [9:0]            RedBox_Y [NUM_ZOMBIE],
  input  logic [NUM_ZOMBIE-1:0] RedBox_Exist,
  output logic [9:0]            Bullet_X [NUM_SLOTS],
  output logic [9:0]            Bullet_Y [NUM_SLOTS],
  output logic [NUM_SLOTS-1:0]  Bullet_Active,
  output logic [NUM_ZOMBIE-1:0] Zombie_Hit,
  output logic [6:0]            Hit_Damage [NUM_ZOMBIE],
  output logic [1:0]            Shot_Dropped,
  output logic                  Ready,
  output logic [1:0]            dbg_state,
  output logic [NUM_SLOTS-1:0]  dbg_owner
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int ZW = (NUM_ZOMBIE > 1) ? $clog2(NUM_ZOMBIE) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_SLOTS - 1);
  localparam logic signed [10:0] SPD  = 11'(BULLET_SPEED);
  localparam logic signed [10:0] XLIM = 11'(SCREEN_W);
  localparam logic signed [10:0] YLIM = 11'(SCREEN_H);

  state_t state, state_nxt;
  logic [SW-1:0] idx;
  dir_t sdir [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] owner;
  logic [6:0] sdmg [NUM_SLOTS];
  logic [6:0] acc [NUM_ZOMBIE];
  logic [NUM_ZOMBIE-1:0] hitflag, match, hit_sel;
  logic [ZW-1:0] first;
  logic [1:0] shot_prev, pend, shot_rise, sp_ok;
  logic [SW-1:0] sp_slot [2];
  logic [SW-1:0] f0, f1;
  logic f0_ok, f1_ok, frame_prev, frame_edge;
  logic signed [10:0] nx [NUM_SLOTS];
  logic signed [10:0] ny [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] in_bounds;

  assign shot_rise = If_Shot & ~shot_prev;
  assign dbg_state = state;
  assign dbg_owner = owner;
  assign Zombie_Hit = (state == ST_REPORT) ? hitflag : '0;

  always_comb begin
    for (int z = 0; z < NUM_ZOMBIE; z++) begin
      Hit_Damage[z] = (state == ST_REPORT) ? acc[z] : '0;
    end
  end

  // P0 always takes the lowest free slot; P1 takes the next one if P0 also spawns.
  always_comb begin
    f0 = '0; f0_ok = 1'b0; f1 = '0; f1_ok = 1'b0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!Bullet_Active[s]) begin f0 = SW'(s); f0_ok = 1'b1; end
    end
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!Bullet_Active[s] && (SW'(s) != f0)) begin f1 = SW'(s); f1_ok = 1'b1; end
    end
    sp_slot[0] = f0;
    sp_ok[0]   = f0_ok;
    sp_slot[1] = pend[0] ? f1 : f0;
    sp_ok[1]   = pend[0] ? f1_ok : f0_ok;
  end

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      nx[s] = $signed({1'b0, Bullet_X[s]});
      ny[s] = $signed({1'b0, Bullet_Y[s]});
      case (sdir[s])
        DIR_UP:    ny[s] = ny[s] - SPD;
        DIR_DOWN:  ny[s] = ny[s] + SPD;
        DIR_LEFT:  nx[s] = nx[s] - SPD;
        default:   nx[s] = nx[s] + SPD;
      endcase
      in_bounds[s] = !nx[s][10] && (nx[s] < XLIM) && !ny[s][10] && (ny[s] < YLIM);
    end
  end

  bullet_hit_check #(.NUM_ZOMBIE(NUM_ZOMBIE), .HIT_RADIUS(HIT_RADIUS)) u_hit (
    .bx(Bullet_X[idx]), .by(Bullet_Y[idx]), .zx(RedBox_X), .zy(RedBox_Y),
    .exist(RedBox_Exist), .match(match), .first(first)
  );

  // The lowest hit is always in the mask, so piercing only widens the credit set.
  always_comb begin
    hit_sel = '0;
`ifdef BULLET_PIERCE_EN
    hit_sel = match;
`endif
    if (|match) hit_sel[first] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (frame_edge) state_nxt = ST_MOVE;
      ST_MOVE:  state_nxt = ST_CHECK;
      ST_CHECK: if (idx == LAST) state_nxt = ST_REPORT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE; idx <= '0; owner <= '0; hitflag <= '0;
      shot_prev <= '0; pend <= '0; frame_prev <= 1'b0; frame_edge <= 1'b0;
      Bullet_Active <= '0; Shot_Dropped <= '0; Ready <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        Bullet_X[s] <= '0; Bullet_Y[s] <= '0; sdir[s] <= DIR_UP; sdmg[s] <= '0;
      end
      for (int z = 0; z < NUM_ZOMBIE; z++) acc[z] <= '0;
    end else begin
      shot_prev    <= If_Shot;
      frame_prev   <= frame_clk;
      frame_edge   <= frame_clk & ~frame_prev;
      Shot_Dropped <= '0;
      Ready        <= Start && (state_nxt == ST_IDLE);
      if (!Start) begin
        state <= ST_IDLE; idx <= '0; pend <= '0; hitflag <= '0; Bullet_Active <= '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          Bullet_X[s] <= '0; Bullet_Y[s] <= '0;
        end
        for (int z = 0; z < NUM_ZOMBIE; z++) acc[z] <= '0;
      end else begin
        state <= state_nxt;
        pend  <= pend | shot_rise;
        case (state)
          ST_IDLE: begin
            pend <= shot_rise;
            for (int p = 0; p < 2; p++) begin
              if (pend[p]) begin
                if (sp_ok[p]) begin
                  Bullet_Active[sp_slot[p]] <= 1'b1;
                  Bullet_X[sp_slot[p]]      <= Player_X[p];
                  Bullet_Y[sp_slot[p]]      <= Player_Y[p];
                  sdir[sp_slot[p]]          <= dir_t'(Player_Dir[p]);
                  owner[sp_slot[p]]         <= p[0];
                  sdmg[sp_slot[p]]          <= Bullet_Damage[p];
                end else begin
                  Shot_Dropped[p] <= 1'b1;
                end
              end
            end
          end
          ST_MOVE: begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
              if (Bullet_Active[s]) begin
                if (in_bounds[s]) begin
                  Bullet_X[s] <= nx[s][9:0];
                  Bullet_Y[s] <= ny[s][9:0];
                end else begin
                  Bullet_Active[s] <= 1'b0;
                end
              end
            end
          end
          ST_CHECK: begin
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
            if (Bullet_Active[idx]) begin
              for (int z = 0; z < NUM_ZOMBIE; z++) begin
                if (hit_sel[z]) begin
                  acc[z]     <= sat_add(acc[z], sdmg[idx]);
                  hitflag[z] <= 1'b1;
                end
              end
`ifndef BULLET_PIERCE_EN
              if (|match) Bullet_Active[idx] <= 1'b0;
`endif
            end
          end
          default: begin
            hitflag <= '0;
            for (int z = 0; z < NUM_ZOMBIE; z++) acc[z] <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bullet_tracker.sv
// Directed bench for bullet_tracker: per-frame hit reports are predicted into a
// queue at stimulus time and popped when the engine reaches its report phase.
module tb_bullet_tracker;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, Start;
  logic [1:0]  If_Shot;
  logic [6:0]  Bullet_Damage [2];
  logic [9:0]  Player_X [2];
  logic [9:0]  Player_Y [2];
  logic [1:0]  Player_Dir [2];
  logic [9:0]  RedBox_X [10];
  logic [9:0]  RedBox_Y [10];
  logic [9:0]  RedBox_Exist;
  logic [9:0]  Bullet_X [8];
  logic [9:0]  Bullet_Y [8];
  logic [7:0]  Bullet_Active;
  logic [9:0]  Zombie_Hit;
  logic [6:0]  Hit_Damage [10];
  logic [1:0]  Shot_Dropped;
  logic        Ready;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_owner;

  int vectors = 0;
  int miscompares = 0;
  logic [79:0] exp_q [$];
  logic [9:0]  e_hit;
  logic [6:0]  e_dmg [10];

  bullet_tracker dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Start(Start),
    .If_Shot(If_Shot), .Bullet_Damage(Bullet_Damage),
    .Player_X(Player_X), .Player_Y(Player_Y), .Player_Dir(Player_Dir),
    .RedBox_X(RedBox_X), .RedBox_Y(RedBox_Y), .RedBox_Exist(RedBox_Exist),
    .Bullet_X(Bullet_X), .Bullet_Y(Bullet_Y), .Bullet_Active(Bullet_Active),
    .Zombie_Hit(Zombie_Hit), .Hit_Damage(Hit_Damage), .Shot_Dropped(Shot_Dropped),
    .Ready(Ready), .dbg_state(dbg_state), .dbg_owner(dbg_owner)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] pack(input logic [9:0] h, input logic [6:0] d [10]);
    logic [79:0] r;
    r = '0;
    r[79:70] = h;
    for (int z = 0; z < 10; z++) r[z*7 +: 7] = d[z];
    return r;
  endfunction

  task automatic clear_exp();
    e_hit = '0;
    for (int z = 0; z < 10; z++) e_dmg[z] = '0;
  endtask

  task automatic push_exp();
    exp_q.push_back(pack(e_hit, e_dmg));
  endtask

  task automatic shoot(input int p);
    If_Shot[p] = 1'b1;
    tick(); tick();
    If_Shot[p] = 1'b0;
    tick();
  endtask

  // Runs one frame; dbl adds a second frame_clk rise mid-CHECK that must be ignored.
  task automatic run_frame(input bit dbl);
    int n;
    logic [79:0] e;
    n = 0;
    frame_clk = 1'b1;
    do begin
      tick();
      n++;
      if (n == 3) frame_clk = 1'b0;
      if (dbl && n == 6) frame_clk = 1'b1;
      if (dbl && n == 8) frame_clk = 1'b0;
    end while (dbg_state != 2'd3 && n < 40);
    frame_clk = 1'b0;
    check("frame_latency", 80'(n), 80'd11);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed report with no expected entry");
    end else begin
      e = exp_q.pop_front();
      check("report", pack(Zombie_Hit, Hit_Damage), e);
    end
    tick();
    check("pulse_clear", pack(Zombie_Hit, Hit_Damage), 80'd0);
    n = 0;
    while (!Ready && n < 40) begin tick(); n++; end
    check("back_to_idle", 80'(Ready), 80'd1);
    if (dbl) begin
      repeat (3) tick();
      check("extra_edge_ignored", 80'(dbg_state), 80'd0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    Reset = 1'b1; Start = 1'b0; frame_clk = 1'b0; If_Shot = 2'b00;
    RedBox_Exist = '0;
    for (int p = 0; p < 2; p++) begin
      Bullet_Damage[p] = '0; Player_X[p] = '0; Player_Y[p] = '0; Player_Dir[p] = '0;
    end
    for (int z = 0; z < 10; z++) begin RedBox_X[z] = 10'd1000; RedBox_Y[z] = 10'd1000; end
    clear_exp();

    // reset state
    repeat (2) tick();
    check("rst_active", 80'(Bullet_Active), 80'd0);
    check("rst_hits", pack(Zombie_Hit, Hit_Damage), 80'd0);
    check("rst_dropped", 80'(Shot_Dropped), 80'd0);
    check("rst_ready", 80'(Ready), 80'd0);
    check("rst_bx0", 80'(Bullet_X[0]), 80'd0);
    Reset = 1'b0; Start = 1'b1;
    tick();
    check("ready_after_rst", 80'(Ready), 80'd1);

    // single hit on zombie 3 in the second frame
    Player_X[0] = 10'd100; Player_Y[0] = 10'd100; Player_Dir[0] = 2'd3; Bullet_Damage[0] = 7'd5;
    RedBox_X[3] = 10'd120; RedBox_Y[3] = 10'd100; RedBox_Exist = 10'h008;
    If_Shot[0] = 1'b1;
    tick();
    check("spawn_not_yet", 80'(Bullet_Active), 80'd0);
    tick();
    check("spawn_active", 80'(Bullet_Active), 80'h01);
    check("spawn_x", 80'(Bullet_X[0]), 80'd100);
    If_Shot[0] = 1'b0;
    tick();
    clear_exp(); push_exp();
    run_frame(1'b0);
    check("move_x", 80'(Bullet_X[0]), 80'd108);
    clear_exp(); e_hit = 10'h008; e_dmg[3] = 7'd5; push_exp();
    run_frame(1'b0);
    check("hit_slot_freed", 80'(Bullet_Active), 80'd0);

    // edge exit, with an extra frame rise arriving mid-CHECK
    RedBox_Exist = '0;
    Player_X[0] = 10'd636; Player_Y[0] = 10'd200; Player_Dir[0] = 2'd3;
    shoot(0);
    check("edge_spawn", 80'(Bullet_Active), 80'h01);
    clear_exp(); push_exp();
    run_frame(1'b1);
    check("edge_deactivated", 80'(Bullet_Active), 80'd0);
    check("edge_x_kept", 80'(Bullet_X[0]), 80'd636);

    // simultaneous spawn
    Player_X[0] = 10'd50;  Player_Y[0] = 10'd50;  Player_Dir[0] = 2'd1;
    Player_X[1] = 10'd300; Player_Y[1] = 10'd300; Player_Dir[1] = 2'd0;
    Bullet_Damage[1] = 7'd9;
    If_Shot = 2'b11;
    tick(); tick();
    check("both_active", 80'(Bullet_Active), 80'h03);
    check("p0_slot0_x", 80'(Bullet_X[0]), 80'd50);
    check("p1_slot1_x", 80'(Bullet_X[1]), 80'd300);
    check("owners", 80'(dbg_owner[1:0]), 80'b10);
    If_Shot = 2'b00;
    tick();

    // pool full
    repeat (6) shoot(0);
    check("pool_full", 80'(Bullet_Active), 80'hFF);
    If_Shot[1] = 1'b1;
    tick(); tick();
    check("drop_pulse", 80'(Shot_Dropped), 80'b10);
    If_Shot[1] = 1'b0;
    tick();
    check("drop_one_cycle", 80'(Shot_Dropped), 80'd0);
    check("pool_still_full", 80'(Bullet_Active), 80'hFF);

    // Start low clears the pool
    Start = 1'b0;
    tick();
    check("start_clear", 80'(Bullet_Active), 80'd0);
    check("start_ready_low", 80'(Ready), 80'd0);
    Start = 1'b1;
    tick();
    check("start_ready_high", 80'(Ready), 80'd1);

    // accumulate: 8 bullets x 20 onto overlapping zombies 0 and 1
    RedBox_X[0] = 10'd400; RedBox_Y[0] = 10'd208;
    RedBox_X[1] = 10'd402; RedBox_Y[1] = 10'd210;
    RedBox_Exist = 10'h003;
    for (int p = 0; p < 2; p++) begin
      Player_X[p] = 10'd400; Player_Y[p] = 10'd200; Player_Dir[p] = 2'd1;
      Bullet_Damage[p] = 7'd20;
    end
    repeat (4) begin
      If_Shot = 2'b11;
      tick(); tick();
      If_Shot = 2'b00;
      tick();
    end
    check("acc_pool_full", 80'(Bullet_Active), 80'hFF);
    clear_exp(); e_hit = 10'h001; e_dmg[0] = 7'd127;
`ifdef BULLET_PIERCE_EN
    e_hit = 10'h003; e_dmg[1] = 7'd127;
`endif
    push_exp();
    run_frame(1'b0);
    check("acc_move_y", 80'(Bullet_Y[0]), 80'd208);
`ifdef BULLET_PIERCE_EN
    check("acc_after", 80'(Bullet_Active), 80'hFF);
`else
    check("acc_after", 80'(Bullet_Active), 80'h00);
`endif

    // asynchronous reset during CHECK
    Start = 1'b0; tick(); Start = 1'b1; tick();
    RedBox_Exist = '0;
    shoot(0);
    frame_clk = 1'b1;
    n = 0;
    while (dbg_state != 2'd2 && n < 40) begin
      tick();
      n++;
      if (n == 3) frame_clk = 1'b0;
    end
    frame_clk = 1'b0;
    check("reach_check", 80'(dbg_state), 80'd2);
    Reset = 1'b1;
    #1;
    check("midrst_active", 80'(Bullet_Active), 80'd0);
    check("midrst_hits", pack(Zombie_Hit, Hit_Damage), 80'd0);
    check("midrst_ready", 80'(Ready), 80'd0);
    check("midrst_state", 80'(dbg_state), 80'd0);
    check("midrst_bx0", 80'(Bullet_X[0]), 80'd0);
    tick();
    Reset = 1'b0;
    tick();
    check("ready_after_midrst", 80'(Ready), 80'd1);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
